mat_feeder: RTL

MAT_FEEDER -- requirements
Module: mat_feeder

---
 rtl/mat_feeder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mat_feeder.sv
// rtl/mat_feeder.sv - loads an NxN matrix row-major, then streams its columns into a skewed MAC array.
// Optional MAT_FEEDER_REPLAY_EN: FIN returns to LOADED for re-streaming; i_clr_buf discards the matrix.
module mat_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [DATA_WIDTH-1:0]   i_in_data,
  input  logic                    i_start,
`ifdef MAT_FEEDER_REPLAY_EN
  input  logic                    i_clr_buf,
`endif
  output logic                    o_acc_clr_n,
  output logic                    o_out_valid,
  output logic [N*DATA_WIDTH-1:0] o_out_data,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int CW = $clog2(2*N-1);
  localparam int LW = $clog2(N*N);
  localparam logic [LW-1:0] LAST_LOAD   = LW'(N*N-1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(N-1);
  localparam logic [CW-1:0] FLUSH_LAST  = CW'(2*N-3);

  typedef enum logic [2:0] {S_IDLE, S_LOADED, S_CLEAR, S_STREAM, S_FLUSH, S_FIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LW-1:0]           r_load_cnt, w_load_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_buf [N*N];
  logic                    r_in_ready, r_out_valid, r_acc_clr_n, r_done;
  logic [N*DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic                    w_accept;

  assign w_accept    = i_in_valid & r_in_ready;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_acc_clr_n = r_acc_clr_n;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_LOADED);

  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = r_load_cnt;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (r_load_cnt == LAST_LOAD) begin
            w_state_nxt = S_LOADED;
            w_load_nxt  = '0;
          end else begin
            w_load_nxt = r_load_cnt + LW'(1);
          end
        end
      end
      S_LOADED: begin
`ifdef MAT_FEEDER_REPLAY_EN
        if (i_clr_buf)    w_state_nxt = S_IDLE;
        else if (i_start) w_state_nxt = S_CLEAR;
`else
        if (i_start) w_state_nxt = S_CLEAR;
`endif
      end
      S_CLEAR: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (r_cnt == STREAM_LAST) w_state_nxt = S_FLUSH;
        else                      w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) w_state_nxt = S_FIN;
        else                     w_cnt_nxt   = r_cnt + CW'(1);
      end
`ifdef MAT_FEEDER_REPLAY_EN
      S_FIN: w_state_nxt = S_LOADED;
`else
      S_FIN: w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_out_data_nxt = '0;
    if (w_state_nxt == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        w_out_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_buf[LW'(i*N) + LW'(w_cnt_nxt)];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_load_cnt  <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_acc_clr_n <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_cnt  <= w_load_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_FLUSH);
      r_out_data  <= w_out_data_nxt;
      r_acc_clr_n <= (w_state_nxt != S_CLEAR);
      r_done      <= (w_state_nxt == S_FIN);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_buf[r_load_cnt] <= i_in_data;
  end

endmodule
